// File: rtl/viterbi_pkg.sv
// Shared trellis helpers for the parametrised Viterbi decoder: state sizing,
// encoder branch outputs and the 2-bit Hamming distance used as branch metric.
package viterbi_pkg;

    localparam int MAX_K = 7;

    typedef logic [MAX_K-1:0] poly_t;
    typedef logic [MAX_K-2:0] state_t;

    function automatic int ns_of(input int k);
        return 1 << (k - 1);
    endfunction

    // Encoder register is {b, state}; bit k-1 holds the newest input bit.
    function automatic logic [1:0] enc_out(input int k, input poly_t g0, input poly_t g1,
                                           input state_t state, input logic b);
        poly_t r;
        r = poly_t'(state) | (poly_t'(b) << (k - 1));
        return {^(r & g0), ^(r & g1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Add-compare-select for one trellis state: two predecessor metrics plus their
// branch metrics, lower sum survives, predecessor p0 wins a tie.
module viterbi_acs_unit
    import viterbi_pkg::*;
#(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      bo0_i,
    input  logic [1:0]      bo1_i,
    input  logic [1:0]      sym_i,
    output logic [PM_W-1:0] pm_o,
    output logic            sel_o
);

    logic [PM_W-1:0] m0;
    logic [PM_W-1:0] m1;

    assign m0    = pm0_i + {{(PM_W-2){1'b0}}, hamming2(sym_i, bo0_i)};
    assign m1    = pm1_i + {{(PM_W-2){1'b0}}, hamming2(sym_i, bo1_i)};
    assign sel_o = (m1 < m0);
    assign pm_o  = sel_o ? m1 : m0;

endmodule

// File: rtl/viterbi_dec_param.sv
// Parametrised hard-decision rate-1/2 Viterbi decoder with register-exchange survivors.
// Define VITERBI_ERRCNT_EN to build the corrected-symbol counter driven on err_cnt.
module viterbi_dec_param
    import viterbi_pkg::*;
#(
    parameter int           K        = 3,
    parameter logic [K-1:0] G0       = 3'b111,
    parameter logic [K-1:0] G1       = 3'b101,
    parameter int           TB_DEPTH = 15,
    parameter int           PM_W     = 6
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [1:0]  in_sym,
    output logic        out_valid,
    output logic        out_bit,
    output logic [15:0] err_cnt
);

    localparam int              NS       = ns_of(K);
    localparam int              SW       = K - 1;
    localparam int              FW       = $clog2(TB_DEPTH + 1);
    localparam poly_t           G0_X     = poly_t'(G0);
    localparam poly_t           G1_X     = poly_t'(G1);
    localparam logic [FW-1:0]   FILL_MAX = FW'(TB_DEPTH);
    localparam logic [PM_W-1:0] PM_INIT  = {2'b01, {(PM_W-2){1'b0}}};

    if (K < 3 || K > MAX_K) begin : g_bad_k
        $error("viterbi_dec_param: K must lie in 3..7");
    end
    if (TB_DEPTH < 5 * (K - 1)) begin : g_bad_depth
        $error("viterbi_dec_param: TB_DEPTH must be at least 5*(K-1)");
    end
    if ((1 << (PM_W - 1)) <= 4 * (K - 1) + 2) begin : g_bad_pm_w
        $error("viterbi_dec_param: PM_W too narrow for normalisation");
    end

    logic [PM_W-1:0]     pm_q   [NS];
    logic [PM_W-1:0]     pm_d   [NS];
    logic [PM_W-1:0]     acs_pm [NS];
    logic [TB_DEPTH-1:0] surv_q [NS];
    logic [TB_DEPTH-1:0] surv_d [NS];
    logic [TB_DEPTH-1:0] surv_x [NS];
    logic [NS-1:0]       acs_sel;
    logic [NS-1:0]       shift_out;
    logic [FW-1:0]       fill_q;
    logic [FW-1:0]       fill_d;
    logic                out_valid_q;
    logic                out_valid_d;
    logic                out_bit_q;
    logic                out_bit_d;
    logic [SW-1:0]       best_idx;
    logic [PM_W-1:0]     best_pm;
    logic                all_msb;
`ifdef VITERBI_ERRCNT_EN
    logic [1:0]          bo_win [NS];
`endif

    // One ACS per state; predecessors {s[K-3:0],0/1}, decided bit s[K-2].
    for (genvar s = 0; s < NS; s++) begin : g_state
        localparam int         P0  = (2 * s) % NS;
        localparam int         P1  = P0 + 1;
        localparam logic       B   = (s >= NS / 2);
        localparam logic [1:0] BO0 = enc_out(K, G0_X, G1_X, state_t'(P0), B);
        localparam logic [1:0] BO1 = enc_out(K, G0_X, G1_X, state_t'(P1), B);

        viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
            .pm0_i (pm_q[P0]),
            .pm1_i (pm_q[P1]),
            .bo0_i (BO0),
            .bo1_i (BO1),
            .sym_i (in_sym),
            .pm_o  (acs_pm[s]),
            .sel_o (acs_sel[s])
        );

        assign surv_x[s]    = acs_sel[s] ? {surv_q[P1][TB_DEPTH-2:0], B}
                                         : {surv_q[P0][TB_DEPTH-2:0], B};
        // The bit pushed out of the survivor is the decision TB_DEPTH symbols back.
        assign shift_out[s] = acs_sel[s] ? surv_q[P1][TB_DEPTH-1] : surv_q[P0][TB_DEPTH-1];
`ifdef VITERBI_ERRCNT_EN
        assign bo_win[s]    = acs_sel[s] ? BO1 : BO0;
`endif
    end

    // Normalisation test and lowest-index minimum over the updated metrics.
    always_comb begin
        all_msb  = 1'b1;
        best_idx = '0;
        best_pm  = acs_pm[0];
        for (int s = 0; s < NS; s++) begin
            all_msb = all_msb & acs_pm[s][PM_W-1];
        end
        for (int s = 1; s < NS; s++) begin
            if (acs_pm[s] < best_pm) begin
                best_pm  = acs_pm[s];
                best_idx = s[SW-1:0];
            end
        end
    end

    // NOTE: every variable gets a hold/default value first so no latch is inferred.
    always_comb begin
        pm_d        = pm_q;
        surv_d      = surv_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;
        if (in_valid) begin
            for (int s = 0; s < NS; s++) begin
                pm_d[s] = acs_pm[s];
                if (all_msb) begin
                    pm_d[s][PM_W-1] = 1'b0;
                end
            end
            surv_d = surv_x;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_bit_d   = shift_out[best_idx];
            end
        end
    end

    // NOTE: the survivor array is reset too, because the restart behaviour
    // depends on every path starting from all-zero history.
    always_ff @(posedge CLK) begin
        if (!RST_N || clr) begin
            for (int s = 0; s < NS; s++) begin
                pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
                surv_q[s] <= '0;
            end
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
        end else begin
            pm_q        <= pm_d;
            surv_q      <= surv_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;

`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_q;
    logic [15:0] err_d;

    always_comb begin
        err_d = err_q;
        if (in_valid && (in_sym != bo_win[best_idx]) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N || clr) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 16'h0000;
`endif

endmodule
